sync_fifo_ctl: RTL

- Next-generation parametrised single-clock FIFO; supersedes the basic sync FIFO in the util library.
- Adds the following over the basic FIFO:
  - selectable standard / first-word-fall-through (FWFT) read mode
  - programmable almost-full and almost-empty thresholds
  - occupancy count output
  - synchronous flush
  - concurrent read/write while full
- Used as the generic buffering element between compute pipeline stages sharing one clock.

---
 rtl/sync_fifo_ctl.sv | 109 ++++++++++
 1 files changed

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: standard or first-word-fall-through read port,
// programmable almost-full/almost-empty thresholds, occupancy count and flush.
module sync_fifo_ctl #(
    parameter int DATA_BIT  = 64,
    parameter int DEPTH     = 16,
    parameter int ADDR_BIT  = $clog2(DEPTH),
    parameter bit FWFT      = 1'b0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                wen,
    input  logic [DATA_BIT-1:0] wdata,
    output logic                wfull,
    output logic                wafull,
    output logic                werror,
    input  logic                ren,
    output logic [DATA_BIT-1:0] rdata,
    output logic                rvalid,
    output logic                rempty,
    output logic                raempty,
    output logic                rerror,
    output logic [ADDR_BIT:0]   count
);

    localparam logic [ADDR_BIT-1:0] LAST_ADDR  = ADDR_BIT'(DEPTH - 1);
    localparam logic [ADDR_BIT:0]   FULL_CNT   = (ADDR_BIT + 1)'(DEPTH);
    localparam logic [ADDR_BIT:0]   AFULL_CNT  = (ADDR_BIT + 1)'(AFULL_TH);
    localparam logic [ADDR_BIT:0]   AEMPTY_CNT = (ADDR_BIT + 1)'(AEMPTY_TH);

    logic [DATA_BIT-1:0] mem [DEPTH];
    logic [ADDR_BIT-1:0] wptr;
    logic [ADDR_BIT-1:0] rptr;
    logic                rd_ok;
    logic                wr_ok;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [ADDR_BIT-1:0] next_ptr(input logic [ADDR_BIT-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    assign wfull   = (count == FULL_CNT);
    assign wafull  = (count >= AFULL_CNT);
    assign rempty  = (count == '0);
    assign raempty = (count <= AEMPTY_CNT);

    // A write into a full FIFO is only accepted when a read frees a slot on the same edge.
    assign rd_ok = ren && !rempty;
    assign wr_ok = wen && (!wfull || rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok && !flush && !rst) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            werror <= 1'b0;
            rerror <= 1'b0;
        end else if (flush) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            werror <= 1'b0;
            rerror <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= next_ptr(wptr);
            end
            if (rd_ok) begin
                rptr <= next_ptr(rptr);
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
            werror <= wen && !wr_ok;
            rerror <= ren && !rd_ok;
        end
    end

    if (FWFT) begin : g_fwft
        assign rdata  = mem[rptr];
        assign rvalid = !rempty;
    end else begin : g_std
        // rdata deliberately survives flush; only the qualifier drops.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata  <= '0;
                rvalid <= 1'b0;
            end else if (flush) begin
                rvalid <= 1'b0;
            end else begin
                rvalid <= rd_ok;
                if (rd_ok) begin
                    rdata <= mem[rptr];
                end
            end
        end
    end

endmodule
